// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the load/store controller.
// Size codes, FSM state encoding and the alignment check.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // The unused code 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lsb[0];
            default: mis = |lsb;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core request/response and word-memory signals of the load/store controller.
// slave: controller view; master: core and memory side view.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane handling: merges store data into a memory word and
// extracts/extends load data from a memory word.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lsb_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);
    logic [4:0] sh_b;
    logic [4:0] sh_h;
    logic [7:0] lane_b;
    logic [15:0] lane_h;

    assign sh_b = {lsb_i, 3'b000};
    assign sh_h = {lsb_i[1], 4'b0000};

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: merged_o[sh_b +: 8]  = wdata_i[7:0];
            SZ_HALF: merged_o[sh_h +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

    always_comb begin
        lane_b = word_i[sh_b +: 8];
        lane_h = word_i[sh_h +: 16];
        case (size_i)
            SZ_BYTE: load_o = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
            SZ_HALF: load_o = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
            default: load_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the core memory stage and a word-wide memory.
// Sub-word stores run as read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int ERR_ON_MISALIGN = 1
) (
    input logic              CLK,
    input logic              RST_N,
    mem_access_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;

    logic        ready;
    logic        accept;
    logic        misaligned;
    logic [1:0]  size_n;
    logic [31:0] merged;
    logic [31:0] load_data;

    assign size_n     = norm_size(bus.req_size);
    assign misaligned = is_misaligned(size_n, bus.req_addr[1:0]);
    assign accept     = bus.req_valid & ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned && (ERR_ON_MISALIGN != 0)) state_d = RESP;
                    else if (bus.req_we && size_n == SZ_WORD) state_d = WRITE;
                    else                                      state_d = READ;
                end
            end
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready          = (state_q == IDLE) && RST_N;
        bus.mem_we     = (state_q == WRITE);
        bus.mem_wd     = (state_q == WRITE) ? merged : 32'h0;
        bus.rsp_valid  = (state_q == RESP);
        bus.rsp_err    = (state_q == RESP) && err_q;
        bus.rsp_rdata  = ((state_q == RESP) && !we_q && !err_q) ? load_data : 32'h0;
    end

    assign bus.req_ready = ready;
    assign bus.mem_a     = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        if (accept) begin
            addr_d = bus.req_addr;
            // Without error reporting, misaligned accesses are snapped to their natural boundary.
            if (ERR_ON_MISALIGN == 0) begin
                if (size_n == SZ_HALF)      addr_d[0]   = 1'b0;
                else if (size_n == SZ_WORD) addr_d[1:0] = 2'b00;
            end
            size_d  = size_n;
            we_d    = bus.req_we;
            uns_d   = bus.req_unsigned;
            err_d   = misaligned && (ERR_ON_MISALIGN != 0);
            wdata_d = bus.req_wdata;
        end
        if (state_q == READ) data_d = bus.mem_rd;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    mem_lane_align u_align (
        .word_i     (data_q),
        .wdata_i    (wdata_q),
        .lsb_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .merged_o   (merged),
        .load_o     (load_data)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed and random load/store traffic
// against a word-array reference model, with a 16-word memory behind the DUT.
module tb_mem_access_ctrl;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_access_ctrl_if #(.ADDR_W(32)) bus();

    mem_access_ctrl #(.ADDR_W(32), .ERR_ON_MISALIGN(1)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    logic [31:0] tb_mem    [16] = '{default: 32'h0};
    logic [31:0] model_mem [16] = '{default: 32'h0};

    assign bus.mem_rd = tb_mem[bus.mem_a[5:2]];
    always @(posedge CLK) if (bus.mem_we) tb_mem[bus.mem_a[5:2]] <= bus.mem_wd;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int we_seen = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] load_ref(input logic [31:0] word, input logic [1:0] lsb,
                                             input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> (8 * lsb)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * lsb[1])) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_ref(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lsb, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd2) return wdata;
        sh   = (sz == 2'd0) ? 8 * lsb : 16 * lsb[1];
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        exp_t e;
        logic [1:0] sz;
        bit mis;
        int w;
        int waitc;
        sz  = (size == 2'd3) ? 2'd2 : size;
        mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        w   = int'(addr[5:2]);
        e.waddr = addr & 32'hFFFF_FFFC;
        e.wd    = 32'h0;
        e.nwr   = 0;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (mis) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (we) begin
            e.wd  = store_ref(model_mem[w], wdata, addr[1:0], sz);
            e.nwr = 1;
            e.lat = (sz == 2'd2) ? 2 : 3;
        end else begin
            e.rdata = load_ref(model_mem[w], addr[1:0], sz, uns);
            e.lat   = 2;
        end
        waitc = 0;
        @(negedge CLK);
        while (!bus.req_ready && waitc < 50) begin
            @(negedge CLK);
            waitc++;
        end
        if (!bus.req_ready) begin
            checks++;
            $display("FAIL ready_timeout: req_ready still %b after %0d cycles", bus.req_ready, waitc);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        e.acc = cyc - 1;
        if (track) begin
            if (!mis && we) model_mem[w] = e.wd;
            q.push_back(e);
        end
    endtask

    // Monitor: checks memory-side writes and every response against the queue head.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            we_seen = 0;
        end else begin
            if (q.size() > 0) chk("ready_busy", {31'h0, bus.req_ready}, 32'h0);
            if (bus.mem_we) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_we: mem_we=1 at mem_a=%h with nothing outstanding", bus.mem_a);
                end else begin
                    chk("mem_a", bus.mem_a, q[0].waddr);
                    chk("mem_wd", bus.mem_wd, q[0].wd);
                end
                we_seen++;
            end
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h with nothing outstanding", bus.rsp_rdata);
                end else begin
                    e = q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("write_count", 32'(we_seen), 32'(e.nwr));
                end
                we_seen = 0;
            end
        end
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        #3;
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_wd", bus.mem_wd, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        issue(1, 2'd2, 0, 32'd0, 32'hFF11_931F, 1);
        issue(0, 2'd2, 0, 32'd0, 32'h0, 1);
        issue(1, 2'd0, 0, 32'd2, 32'h0000_0013, 1);
        issue(0, 2'd2, 0, 32'd0, 32'h0, 1);
        issue(0, 2'd0, 0, 32'd3, 32'h0, 1);
        issue(0, 2'd0, 1, 32'd2, 32'h0, 1);
        issue(0, 2'd1, 0, 32'd2, 32'h0, 1);
        issue(0, 2'd1, 1, 32'd0, 32'h0, 1);
        issue(0, 2'd2, 0, 32'd2, 32'h0, 1);
        issue(0, 2'd3, 0, 32'd0, 32'h0, 1);
        issue(1, 2'd1, 0, 32'd8, 32'h1234_ABCD, 1);
        issue(0, 2'd2, 0, 32'd8, 32'h0, 1);
        repeat (4) @(negedge CLK);
        chk("word0_after_rmw", tb_mem[0], 32'hFF13_931F);
        chk("word2_half_store", tb_mem[2], 32'h0000_ABCD);

        // Abort a word store in its WRITE cycle.
        issue(1, 2'd2, 0, 32'd16, 32'h1234_5678, 1);
        issue(1, 2'd2, 0, 32'd16, 32'hDEAD_BEEF, 0);
        RST_N = 1'b0;
        #1;
        chk("abort_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("abort_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("abort_mem_unchanged", tb_mem[4], 32'h1234_5678);
        issue(0, 2'd2, 0, 32'd16, 32'h0, 1);

        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom, 1);
        end

        repeat (6) @(negedge CLK);
        chk("queue_drained", 32'(q.size()), 32'h0);
        for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], model_mem[i]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side load/store controller that drives the word-wide data memory (`memoria`) on behalf of the RISC-V core. It accepts one byte, halfword or word request at a time over a valid/ready handshake and issues word accesses on A/WE/WD/RD. Sub-word stores are done as read-modify-write, and load data is extracted and sign- or zero-extended. It sits between the core's execute/memory stage and `memoria`, in the same clock domain.

Parameters:
ADDR_W, 32, byte-address width of the request and memory address buses
ERR_ON_MISALIGN, 1, 1: misaligned request is answered with an error and no memory access; 0: address low bits are forced to alignment and the access proceeds

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  core request valid
REQ_READY  out  1  controller can accept a request; equals (state==IDLE) & RST_N
REQ_WE  in  1  1 = store, 0 = load
REQ_SIZE  in  2  00 byte, 01 half, 10 word; 11 is treated as word
REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0
REQ_ADDR  in  ADDR_W  byte address
REQ_WDATA  in  32  store data, right-justified
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  32  extended load data; 0 for stores and errors
RSP_ERR  out  1  misaligned access, valid with RSP_VALID
MEM_A  out  ADDR_W  memory address, always word-aligned {addr[ADDR_W-1:2],2'b00}
MEM_WE  out  1  memory write enable, sampled by memory at CLK rise
MEM_WD  out  32  memory write data
MEM_RD  in  32  memory read data, combinational from MEM_A

Behaviour:
- Reset (RST_N low, async):
  - state=IDLE.
  - MEM_A=0, MEM_WD=0, MEM_WE=0.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0.
  - Request registers cleared.
  - REQ_READY=0 while RST_N is low.
- Handshake: a request is accepted at the CLK edge where REQ_VALID & REQ_READY. The controller captures addr, size, we, unsigned and wdata. Request inputs are ignored outside IDLE.
- States: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP: misaligned and ERR_ON_MISALIGN=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - IDLE -> READ: load, or store with size byte/half.
  - IDLE -> WRITE: word store.
  - READ -> RESP: load. MEM_RD is captured into the data register at the end of the READ cycle.
  - READ -> WRITE: sub-word store.
  - WRITE -> RESP.
  - RESP -> IDLE.
- Memory-side outputs:
  - MEM_A is registered at accept and held until the next accept.
  - MEM_WE=1 only in WRITE, decoded from state.
  - MEM_WD is valid in WRITE. For a word store it is wdata. For sub-word stores it is MEM_RD captured in READ with the selected byte lanes replaced (little-endian: byte lane addr[1:0], half lane addr[1]).
- Response:
  - RSP_VALID=1 for exactly the RESP cycle; there is no backpressure.
  - RSP_RDATA for a load is the selected lane, extended per REQ_UNSIGNED.
  - RSP_ERR=1 only for a misaligned request.
- Latency from the accept edge to RSP_VALID high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: the earliest next accept is the cycle after RESP. REQ_READY is 0 during READ, WRITE and RESP.
- Misaligned error: memory is never touched and MEM_WE stays 0.
- Reset mid-operation: MEM_WE drops immediately. A WRITE aborted before its CLK edge leaves memory unchanged. No response is issued.
- Back-to-back accesses: a store followed by a load to the same word returns the new data, because the memory write completes at the WRITE edge before the next READ.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state encoding IDLE, READ, WRITE, RESP.
  - misalign-check function.
- Sub-module mem_lane_align (combinational):
  - Store path: inputs word, wdata, addr[1:0], size; output merged word.
  - Load path: inputs word, addr[1:0], size, unsigned; output extended load data.

Test Plan:
- Word store 0xFF11931F at addr 0, then word load at addr 0: MEM_WE high for exactly 1 cycle with MEM_A=0 and MEM_WD=0xFF11931F; RSP_RDATA=0xFF11931F 2 cycles after the load accept.
- Byte store 0x13 at addr 2 over 0xFF11931F: READ then WRITE with MEM_WD=0xFF13931F; a following word load returns 0xFF13931F.
- Loads from word 0xFF13931F:
  - Byte signed at addr 3 -> 0xFFFFFFFF.
  - Byte unsigned at addr 2 -> 0x00000013.
  - Half signed at addr 2 -> 0xFFFFFF13.
  - Half unsigned at addr 0 -> 0x0000931F.
- Word load at addr 2 (ERR_ON_MISALIGN=1): RSP_VALID with RSP_ERR=1 and RSP_RDATA=0 one cycle after accept; MEM_WE never high; word 0 unchanged.
- Halfword store 0xABCD at addr 8 to a zeroed word: MEM_A=8, MEM_WD=0x0000ABCD; a following word load at addr 8 returns 0x0000ABCD; REQ_READY=0 for the 3 busy cycles.
- Drop RST_N low during the WRITE state of a word store: MEM_WE goes 0 asynchronously; no RSP_VALID; memory word unchanged; after release REQ_READY=1 and a new load accepts normally.
